// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: PC sequencing, fixed-latency RAM fetch,
// instruction register with valid/ready handoff, branch redirect and HALT stop.
module fetch_sequencer #(
   parameter int              PC_W      = 8,
   parameter int              INSTR_W   = 32,
   parameter int              FETCH_LAT = 1,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_run,
   output logic [PC_W-1:0]    o_pc_counter,
   output logic               o_fetch_req,
   input  logic [INSTR_W-1:0] i_fetch_data,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_instr_valid,
   input  logic               i_instr_ready,
   input  logic               i_branch_valid,
   input  logic [PC_W-1:0]    i_branch_target,
   output logic               o_halted,
   output logic [15:0]        o_fetch_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_HALT
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    w_pc_nxt;
   logic               r_req;
   logic               w_req_nxt;
   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic               r_halted;
   logic               w_halted_nxt;
   logic [2:0]         r_lat;
   logic [2:0]         w_lat_nxt;
   logic [15:0]        r_cnt;
   logic [15:0]        w_cnt_nxt;
   logic               w_hs;
   logic               w_is_halt;
   logic [15:0]        w_cnt_inc;

   assign w_hs      = r_valid & i_instr_ready;
   assign w_is_halt = (r_instr[27:24] == 4'hF);
   assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_nxt    = 1'b0;
      w_instr_nxt  = r_instr;
      w_valid_nxt  = r_valid;
      w_halted_nxt = r_halted;
      w_lat_nxt    = r_lat;
      w_cnt_nxt    = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (i_run) begin
               w_state_nxt = S_REQ;
               w_req_nxt   = 1'b1;
            end
         end
         S_REQ: begin
            if (i_branch_valid) begin
               w_pc_nxt  = i_branch_target;
               w_req_nxt = 1'b1;
            end else begin
               w_lat_nxt   = 3'(FETCH_LAT);
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_branch_valid) begin
               w_pc_nxt    = i_branch_target;
               w_req_nxt   = 1'b1;
               w_lat_nxt   = 3'd0;
               w_state_nxt = S_REQ;
            end else if (r_lat == 3'd1) begin
               w_instr_nxt = i_fetch_data;
               w_valid_nxt = 1'b1;
               w_lat_nxt   = 3'd0;
               w_state_nxt = S_HOLD;
            end else begin
               w_lat_nxt = r_lat - 3'd1;
            end
         end
         S_HOLD: begin
            if (w_hs) begin
               w_cnt_nxt   = w_cnt_inc;
               w_valid_nxt = 1'b0;
               // HALT outranks a same-cycle branch
               if (w_is_halt) begin
                  w_halted_nxt = 1'b1;
                  w_state_nxt  = S_HALT;
               end else begin
                  w_pc_nxt    = i_branch_valid ? i_branch_target
                                               : r_pc + 1'b1;
                  w_req_nxt   = 1'b1;
                  w_state_nxt = S_REQ;
               end
            end else if (i_branch_valid) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = i_branch_target;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc     <= RESET_PC;
         r_req    <= 1'b0;
         r_instr  <= '0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
         r_lat    <= 3'd0;
         r_cnt    <= 16'd0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_req    <= w_req_nxt;
         r_instr  <= w_instr_nxt;
         r_valid  <= w_valid_nxt;
         r_halted <= w_halted_nxt;
         r_lat    <= w_lat_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign o_pc_counter  = r_pc;
   assign o_fetch_req   = r_req;
   assign o_instr       = r_instr;
   assign o_instr_valid = r_valid;
   assign o_halted      = r_halted;
   assign o_fetch_count = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: latency-pipe RAM, age-based reference model,
// directed scenarios followed by randomized traffic.
module tb_fetch_sequencer;

   localparam int         L  = 2;
   localparam logic [7:0] RP = 8'hFE;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        run = 1'b0;
   logic [7:0]  pc_counter;
   logic        fetch_req;
   logic [31:0] fetch_data = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch_valid = 1'b0;
   logic [7:0]  branch_target = '0;
   logic        halted;
   logic [15:0] fetch_count;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .PC_W(8), .INSTR_W(32), .FETCH_LAT(L), .RESET_PC(RP)
   ) u_dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_run(run),
      .o_pc_counter(pc_counter),
      .o_fetch_req(fetch_req),
      .i_fetch_data(fetch_data),
      .o_instr(instr),
      .o_instr_valid(instr_valid),
      .i_instr_ready(instr_ready),
      .i_branch_valid(branch_valid),
      .i_branch_target(branch_target),
      .o_halted(halted),
      .o_fetch_count(fetch_count)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] mem [256];
   logic [7:0]  pp [L];
   logic        pr [L];

   // reference model: age = cycles since the live fetch_req, -1 when none
   logic        m_started, m_halt, m_req, m_valid;
   logic [7:0]  m_pc;
   logic [31:0] m_instr;
   logic [15:0] m_cnt;
   int          m_age;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0; m_halt = 1'b0; m_req = 1'b0; m_valid = 1'b0;
      m_pc = RP; m_instr = '0; m_cnt = '0; m_age = -1;
      for (int k = 0; k < L; k++) begin pp[k] = '0; pr[k] = 1'b0; end
   endtask

   task automatic model_step();
      if (m_halt) begin
      end else if (!m_started) begin
         if (run) begin m_started = 1'b1; m_req = 1'b1; m_age = 0; end
      end else if (m_valid) begin
         m_req = 1'b0;
         if (instr_ready) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_valid = 1'b0;
            if (m_instr[27:24] == 4'hF) m_halt = 1'b1;
            else begin
               m_pc = branch_valid ? branch_target : m_pc + 8'd1;
               m_req = 1'b1; m_age = 0;
            end
         end else if (branch_valid) begin
            m_valid = 1'b0; m_pc = branch_target; m_req = 1'b1; m_age = 0;
         end
      end else begin
         if (branch_valid) begin
            m_pc = branch_target; m_req = 1'b1; m_age = 0;
         end else if (m_age == L) begin
            m_instr = fetch_data; m_valid = 1'b1; m_req = 1'b0; m_age = -1;
         end else begin
            m_req = 1'b0; m_age++;
         end
      end
   endtask

   task automatic compare();
      chk("pc", 32'(pc_counter), 32'(m_pc));
      chk("fetch_req", 32'(fetch_req), 32'(m_req));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr", instr, m_instr);
      chk("halted", 32'(halted), 32'(m_halt));
      chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
   endtask

   task automatic step(input logic r, input logic b, input logic [7:0] t,
                       input logic rdy);
      run = r; branch_valid = b; branch_target = t; instr_ready = rdy;
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      cyc++;
      fetch_data = pr[L-1] ? mem[pp[L-1]] : $urandom;
      for (int k = L - 1; k > 0; k--) begin
         pp[k] = pp[k-1]; pr[k] = pr[k-1];
      end
      pp[0] = pc_counter; pr[0] = fetch_req;
      compare();
   endtask

   function automatic logic in_wait();
      return m_started && !m_halt && !m_valid && !m_req && m_age >= 1;
   endfunction

   logic [7:0]  exp_pcs [4];
   logic [7:0]  got_pcs [$];
   logic        found;
   logic [15:0] k0;
   int          nreq;

   initial begin
      exp_pcs[0] = 8'hFE; exp_pcs[1] = 8'hFF;
      exp_pcs[2] = 8'h00; exp_pcs[3] = 8'h01;
      for (int i = 0; i < 256; i++) mem[i] = $urandom & ~32'h0800_0000;
      mem[8'hFE] = 32'h0100_0000;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compare();
      chk("reset_pc", 32'(pc_counter), 32'h0000_00FE);
      rst_n = 1'b1;

      // startup latency and wrap-around pc sequence
      step(1, 0, 0, 1);
      chk("req_c1", 32'(fetch_req), 32'd1);
      chk("pc_c1", 32'(pc_counter), 32'h0000_00FE);
      got_pcs.push_back(pc_counter);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      chk("valid_c3", 32'(instr_valid), 32'd0);
      step(1, 0, 0, 1);
      chk("valid_c4", 32'(instr_valid), 32'd1);
      chk("instr_c4", instr, 32'h0100_0000);
      for (int i = 0; i < 30 && got_pcs.size() < 4; i++) begin
         step(0, 0, 0, 1);
         if (fetch_req) got_pcs.push_back(pc_counter);
      end
      chk("pc_seq_len", 32'(got_pcs.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_pcs.size(); i++)
         chk("pc_seq", 32'(got_pcs[i]), 32'(exp_pcs[i]));

      // stall: instr stable, no new fetch, count moves on first ready
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 0, 0, 0);
         found = instr_valid;
      end
      chk("hold_seen", 32'(found), 32'd1);
      k0 = m_cnt;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0);
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_req", 32'(fetch_req), 32'd0);
         chk("stall_cnt", 32'(fetch_count), 32'(k0));
      end
      step(0, 0, 0, 1);
      chk("stall_accept", 32'(fetch_count), 32'(k0) + 32'd1);

      // branch during WAIT
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (in_wait()) found = 1'b1;
         else step(0, 0, 0, 0);
      end
      chk("wait_seen", 32'(found), 32'd1);
      step(0, 1, 8'h40, 0);
      chk("br_wait_req", 32'(fetch_req), 32'd1);
      chk("br_wait_pc", 32'(pc_counter), 32'h0000_0040);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 0, 0, 0);
         found = instr_valid;
      end
      chk("br_wait_valid", 32'(found), 32'd1);
      chk("br_wait_instr", instr, mem[8'h40]);

      // branch together with handshake in HOLD
      k0 = m_cnt;
      step(0, 1, 8'h40, 1);
      chk("br_hs_cnt", 32'(fetch_count), 32'(k0) + 32'd1);
      chk("br_hs_pc", 32'(pc_counter), 32'h0000_0040);
      chk("br_hs_req", 32'(fetch_req), 32'd1);

      // randomized traffic
      for (int i = 0; i < 2500; i++)
         step(1'($urandom), $urandom_range(0, 99) < 8, 8'($urandom),
              $urandom_range(0, 99) < 60);

      // asynchronous reset in the middle of WAIT
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (in_wait()) found = 1'b1;
         else step(1, 0, 0, 1);
      end
      chk("wait_seen2", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare();
      chk("arst_pc", 32'(pc_counter), 32'h0000_00FE);
      step(1, 1, 8'h33, 1);
      step(1, 0, 0, 1);
      rst_n = 1'b1;
      step(1, 0, 0, 1);
      chk("restart_req", 32'(fetch_req), 32'd1);
      chk("restart_pc", 32'(pc_counter), 32'h0000_00FE);

      // HALT: every word carries the HALT opcode
      for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h0F00_0000;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1, 0, 0, 1);
         found = halted;
      end
      chk("halted", 32'(found), 32'd1);
      nreq = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
         if (fetch_req) nreq++;
      end
      chk("halt_no_req", 32'(nreq), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
